// File: rtl/lz_stream_gen.sv
// Burst generator producing an MSB-first bit string of Z zeros, a single one, then fill bits.
// Feeds the streaming leading-zero counter's ivalid/mode/data inputs.
module lz_stream_gen #(
  parameter int WIDTH = 8,
  parameter int WORD  = 4
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [8:0]       zero,
  input  logic [WIDTH-1:0] fill,
  output logic             ready,
  output logic             ovalid,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  localparam int TOTAL = WORD * WIDTH;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state;
  logic [8:0]       k;
  logic [8:0]       fin_q;
  logic [9:0]       zs_q;
  logic [WIDTH-1:0] fill_q;

  logic [9:0]       zs_n;
  logic [8:0]       fin_n;

  // Bit at stream position p: zero before Zs, one at Zs, fill bit after.
  function automatic logic [WIDTH-1:0] gen_word(input logic [8:0] kk,
                                                input logic [9:0] zs,
                                                input logic [WIDTH-1:0] f);
    logic [WIDTH-1:0] w;
    int p;
    w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      p = int'(kk) * WIDTH + (WIDTH - 1 - i);
      if (p < int'(zs))
        w[i] = 1'b0;
      else if (p == int'(zs))
        w[i] = 1'b1;
      else
        w[i] = f[i];
    end
    return w;
  endfunction

  always_comb begin
    zs_n  = ({1'b0, zero} > 10'(TOTAL)) ? 10'(TOTAL) : {1'b0, zero};
    fin_n = 9'(WORD - 1);
    if (mode && (zs_n != 10'(TOTAL)))
      fin_n = 9'(zs_n / 10'(WIDTH));
  end

  // A single-word burst stays in IDLE but holds ready low for its one output cycle.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      ovalid <= 1'b0;
      data   <= '0;
      last   <= 1'b0;
      k      <= '0;
      fin_q  <= '0;
      zs_q   <= '0;
      fill_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready  <= 1'b1;
          ovalid <= 1'b0;
          last   <= 1'b0;
          data   <= '0;
          if (ready && start) begin
            zs_q   <= zs_n;
            fill_q <= fill;
            fin_q  <= fin_n;
            data   <= gen_word(9'd0, zs_n, fill);
            ovalid <= 1'b1;
            ready  <= 1'b0;
            if (fin_n == 9'd0) begin
              last <= 1'b1;
            end else begin
              state <= EMIT;
              k     <= 9'd1;
            end
          end
        end
        EMIT: begin
          if (last) begin
            state  <= IDLE;
            ready  <= 1'b1;
            ovalid <= 1'b0;
            last   <= 1'b0;
            data   <= '0;
            k      <= '0;
          end else begin
            data <= gen_word(k, zs_q, fill_q);
            last <= (k == fin_q);
            k    <= k + 9'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lz_stream_gen.sv
// Directed bench for lz_stream_gen at WIDTH=8, WORD=4; expected words are hand-computed.
module tb_lz_stream_gen;

  localparam int WIDTH = 8;
  localparam int WORD  = 4;

  logic             CLK = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [8:0]       zero;
  logic [WIDTH-1:0] fill;
  logic             ready;
  logic             ovalid;
  logic [WIDTH-1:0] data;
  logic             last;

  int vectors     = 0;
  int miscompares = 0;

  // Packed view {ready, ovalid, last, data} so each cycle is one comparison.
  wire [10:0] status = {ready, ovalid, last, data};

  lz_stream_gen #(.WIDTH(WIDTH), .WORD(WORD)) dut (
    .CLK(CLK), .rst(rst), .start(start), .mode(mode), .zero(zero),
    .fill(fill), .ready(ready), .ovalid(ovalid), .data(data), .last(last)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic launch(input logic [8:0] z, input logic m, input logic [7:0] f);
    zero  = z;
    mode  = m;
    fill  = f;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; zero = '0; fill = '0;
    #3;
    vectors++;
    if (status !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("[TB] FAIL reset: got %h expected %h", status, {3'b100, 8'h00});
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_burst();
    logic [7:0] w [4] = '{8'h00, 8'h3F, 8'hFF, 8'hFF};
    launch(9'd10, 1'b0, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (status !== {1'b0, 1'b1, (i == 3), w[i]}) begin
        miscompares++;
        $display("[TB] FAIL full word%0d: got %h expected %h", i, status, {2'b01, (i == 3), w[i]});
      end
      step();
    end
    vectors++;
    if (status !== {3'b100, 8'h00}) begin
      miscompares++;
      $display("[TB] FAIL full idle: got %h expected %h", status, {3'b100, 8'h00});
    end
    step();
  endtask

  task automatic test_turbo();
    logic [7:0] w [2] = '{8'h00, 8'h20};
    launch(9'd10, 1'b1, 8'h00);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (status !== {1'b0, 1'b1, (i == 1), w[i]}) begin
        miscompares++;
        $display("[TB] FAIL turbo word%0d: got %h expected %h", i, status, {2'b01, (i == 1), w[i]});
      end
      step();
    end
    vectors++;
    if (status !== {3'b100, 8'h00}) begin
      miscompares++;
      $display("[TB] FAIL turbo idle: got %h expected %h", status, {3'b100, 8'h00});
    end
    step();
  endtask

  task automatic test_saturate();
    logic [8:0] zs [2] = '{9'd40, 9'd32};
    logic       md [2] = '{1'b1, 1'b0};
    for (int r = 0; r < 2; r++) begin
      launch(zs[r], md[r], 8'hA5);
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (status !== {1'b0, 1'b1, (i == 3), 8'h00}) begin
          miscompares++;
          $display("[TB] FAIL sat%0d word%0d: got %h expected %h", r, i, status, {2'b01, (i == 3), 8'h00});
        end
        step();
      end
      vectors++;
      if (status !== {3'b100, 8'h00}) begin
        miscompares++;
        $display("[TB] FAIL sat%0d idle: got %h expected %h", r, status, {3'b100, 8'h00});
      end
      step();
    end
  endtask

  task automatic test_turbo_last_word();
    logic [7:0] w [4] = '{8'h00, 8'h00, 8'h00, 8'h01};
    launch(9'd31, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (status !== {1'b0, 1'b1, (i == 3), w[i]}) begin
        miscompares++;
        $display("[TB] FAIL z31 word%0d: got %h expected %h", i, status, {2'b01, (i == 3), w[i]});
      end
      step();
    end
    step();
  endtask

  task automatic test_single_word();
    launch(9'd0, 1'b1, 8'h00);
    vectors++;
    if (status !== {3'b011, 8'h80}) begin
      miscompares++;
      $display("[TB] FAIL single word: got %h expected %h", status, {3'b011, 8'h80});
    end
    step();
    vectors++;
    if (status !== {3'b100, 8'h00}) begin
      miscompares++;
      $display("[TB] FAIL single idle: got %h expected %h", status, {3'b100, 8'h00});
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1 [4] = '{8'h00, 8'h3F, 8'hFF, 8'hFF};
    logic [7:0] w2 [4] = '{8'h1F, 8'hFF, 8'hFF, 8'hFF};
    launch(9'd10, 1'b0, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (status !== {1'b0, 1'b1, (i == 3), w1[i]}) begin
        miscompares++;
        $display("[TB] FAIL b2b first word%0d: got %h expected %h", i, status, {2'b01, (i == 3), w1[i]});
      end
      if (i == 1) begin
        start = 1'b1;
        zero  = 9'd3;
      end
      step();
      start = 1'b0;
    end
    vectors++;
    if (status !== {3'b100, 8'h00}) begin
      miscompares++;
      $display("[TB] FAIL b2b gap: got %h expected %h", status, {3'b100, 8'h00});
    end
    launch(9'd3, 1'b0, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (status !== {1'b0, 1'b1, (i == 3), w2[i]}) begin
        miscompares++;
        $display("[TB] FAIL b2b second word%0d: got %h expected %h", i, status, {2'b01, (i == 3), w2[i]});
      end
      step();
    end
    step();
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] w1 [3] = '{8'h00, 8'h3F, 8'hFF};
    logic [7:0] w2 [4] = '{8'h01, 8'hFF, 8'hFF, 8'hFF};
    launch(9'd10, 1'b0, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (status !== {3'b010, w1[i]}) begin
        miscompares++;
        $display("[TB] FAIL abort word%0d: got %h expected %h", i, status, {3'b010, w1[i]});
      end
      if (i < 2) step();
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (status !== {3'b100, 8'h00}) begin
      miscompares++;
      $display("[TB] FAIL abort reset: got %h expected %h", status, {3'b100, 8'h00});
    end
    step();
    rst = 1'b0;
    step();
    vectors++;
    if (status !== {3'b100, 8'h00}) begin
      miscompares++;
      $display("[TB] FAIL abort after release: got %h expected %h", status, {3'b100, 8'h00});
    end
    launch(9'd7, 1'b0, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (status !== {1'b0, 1'b1, (i == 3), w2[i]}) begin
        miscompares++;
        $display("[TB] FAIL restart word%0d: got %h expected %h", i, status, {2'b01, (i == 3), w2[i]});
      end
      step();
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_turbo();
    test_saturate();
    test_turbo_last_word();
    test_single_word();
    test_back_to_back();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lz_stream_gen.md
Name: lz_stream_gen

Overview:
- Generates a burst of WORD words, each WIDTH bits wide, that carries a requested leading-zero count.
- The burst is read as one MSB-first bit string: word 0 first, bit WIDTH-1 of each word first.
- Bit string content: exactly Z zeros, then a single 1, then fill-pattern bits.
- It is the transmit-side counterpart to the team's streaming leading-zero counter and drives that counter's ivalid/mode/data inputs, both in test fixtures and in the normalization datapath.

Parameters:
- WIDTH, 9'd8: bits per word; supported values 4, 8, 16.
- WORD, 9'd4: words per burst; WORD*WIDTH must be at most 256.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a burst; sampled only when ready=1.
- mode  input  1  0 = full burst, 1 = turbo (stop at the word holding the leading one); latched with start.
- zero  input  9  requested leading-zero count; latched with start.
- fill  input  WIDTH  fill pattern for bits after the leading one; latched with start.
- ready  output  1  idle and able to accept start.
- ovalid  output  1  data is a valid burst word this cycle.
- data  output  WIDTH  burst word.
- last  output  1  final word of the current burst; qualified by ovalid.

Behaviour:
- Reset (asynchronous, active-high, effective immediately): ready=1, ovalid=0, data=0, last=0, state=IDLE, word counter=0, latched registers=0.
- Reset mid-burst: the burst is aborted with no further words; the block restarts in IDLE once rst falls.
- States: IDLE and EMIT. All outputs are registered.
- IDLE, ready=1:
  - start=1 at edge t latches zero, mode and fill.
  - Latched count: Zs = min(zero, WORD*WIDTH).
  - Word 0 is driven on the same edge t, so ovalid=1 in the cycle following the start cycle.
  - The state moves to EMIT with word counter k=1. If word 0 is also the final word, the state stays IDLE instead; see the single-word case below.
- EMIT, ready=0: one word per cycle on consecutive cycles. There is no backpressure and ovalid never drops mid-burst.
- Bit mapping: word k, bit i (WIDTH-1 = MSB) has stream position p = k*WIDTH + (WIDTH-1-i).
  - p < Zs: bit = 0.
  - p == Zs: bit = 1.
  - p > Zs: bit = fill[i]. The same fill word is reused for every word.
- Arithmetic: position compares use at least 10-bit unsigned values. Zs = WORD*WIDTH produces an all-zero burst with no 1 bit.
- Final word:
  - mode=0: word WORD-1.
  - mode=1: the word containing position Zs, i.e. word floor(Zs/WIDTH); if Zs = WORD*WIDTH, word WORD-1.
- last=1 together with ovalid=1 on the final word. On the following edge: state=IDLE, ready=1, ovalid=0, data=0, last=0.
  - Minimum spacing between the final word of one burst and word 0 of the next is therefore one idle cycle.
- Single-word burst (turbo, Zs < WIDTH): word 0 carries last=1; ready is low for that word's cycle only, then returns high.
- start while ready=0: ignored; no queuing, latched values unchanged.
- mode, zero and fill changing after acceptance: no effect on the current burst.
- Outside bursts: ovalid=0, last=0, data=0.

Test Plan (WIDTH=8, WORD=4):
1. start, zero=10, fill=8'hFF, mode=0 -> data 00,3F,FF,FF on 4 consecutive ovalid cycles; last only on the 4th; ready=1 the following cycle.
2. start, zero=10, fill=8'h00, mode=1 -> data 00,20; last on the 2nd word; no 3rd word; ready high the cycle after.
3. zero=40 (saturates to 32), mode=1 -> four words 00,00,00,00, last on the 4th. Same result with mode=0 and zero=32.
4. zero=0, fill=8'h00, mode=1 -> single word 80 with ovalid=1 and last=1; ready low for one cycle only.
5. Burst 1 as in scenario 1. Pulse start with zero=3 during word 1 -> ignored; burst 1 completes unchanged and no second burst is produced. Start on the first ready cycle -> word 0 = 1F when fill=FF.
6. rst asserted during word 2 of a full burst -> ovalid, data, last = 0 and ready=1 immediately. After rst falls, a new start with zero=7 -> 01,FF,FF,FF when fill=FF, mode=0.
